// File: rtl/data_types_pkg.sv
// data_types_pkg: shared UART control word, receiver states and divisor floor.
// Defining UART_RX_MAJORITY_EN raises the divisor floor to 4 so three samples fit before mid-bit+1.
package data_types_pkg;
  typedef struct packed {
    logic       en;
    logic       stop;
    logic       word;
    logic [8:0] br_div;
  } ctrl_reg_t;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [8:0] MIN_DIV = 9'd4;
`else
  localparam logic [8:0] MIN_DIV = 9'd2;
`endif
  function automatic logic [8:0] eff_div(input logic [8:0] br_div);
    return (br_div < MIN_DIV) ? MIN_DIV : br_div;
  endfunction
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: loadable 9-bit down-counter giving a mid-bit tick and a bit-end tick.
module uart_baud_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [8:0] load_val,
  input  logic [8:0] mid_val,
  output logic       mid_tick,
  output logic       end_tick
);
  logic [8:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : cnt_q - 9'd1;
  always_ff @(posedge clk) cnt_q <= !rst ? 9'd0 : cnt_d;
  assign mid_tick = (cnt_q == mid_val);
  assign end_tick = (cnt_q == 9'd0);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8/9 data bits LSB-first, 1/2 stop bits, one-cycle valid strobe.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around mid-bit (divisor floor 4).
module uart_rx
  import data_types_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] control,
  input  logic        rx_in,
  output logic [8:0]  data,
  output logic        valid,
  output logic        busy,
  output logic        frame_err
);
  ctrl_reg_t ctrl;
  rx_state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [8:0] div_q, div_d, shift_q, shift_d, data_q, data_d, div_in, half, mid_val, load_val;
  logic [3:0] bit_q, bit_d;
  logic word_q, word_d, stop_q, stop_d, err_q, err_d, hold_q, hold_d;
  logic valid_q, valid_d, frame_err_q, frame_err_d;
  logic rx_s, smp, detect, load, mid_tick, end_tick, last_data, last_stop;
  assign ctrl   = ctrl_reg_t'(control);
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign div_in = eff_div(ctrl.br_div);
  assign half   = div_q >> 1;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  // hist holds rx_s from one and two cycles ago, so the vote lands at half+1
  assign hist_d  = {hist_q[0], rx_s};
  assign smp     = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
  assign mid_val = div_q - 9'd2 - half;
  always_ff @(posedge clk) hist_q <= !rst ? 2'b11 : hist_d;
`else
  assign smp     = rx_s;
  assign mid_val = div_q - 9'd1 - half;
`endif
  // counter sits at div-1 on the first cycle of each bit; the start bit began the cycle before detect
  assign detect    = (state_q == IDLE) && ctrl.en && !rx_s && !hold_q;
  assign load      = detect || ((state_q != IDLE) && end_tick);
  assign load_val  = detect ? div_in - 9'd2 : div_q - 9'd1;
  assign last_data = (bit_q == (word_q ? 4'd8 : 4'd7));
  assign last_stop = !stop_q || bit_q[0];
  uart_baud_counter u_baud (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .mid_val  (mid_val),
    .mid_tick (mid_tick),
    .end_tick (end_tick)
  );
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    word_d      = word_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    err_d       = err_q;
    data_d      = data_q;
    frame_err_d = frame_err_q;
    valid_d     = 1'b0;
    hold_d      = hold_q && !rx_s;
    if ((state_q != IDLE) && !ctrl.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (detect) begin
          state_d = START;
          div_d   = div_in;
          word_d  = ctrl.word;
          stop_d  = ctrl.stop;
          bit_d   = 4'd0;
          err_d   = 1'b0;
        end
        START: if (mid_tick) state_d = smp ? IDLE : DATA;
        DATA: if (mid_tick) begin
          shift_d = {smp, shift_q[8:1]};
          bit_d   = last_data ? 4'd0 : bit_q + 4'd1;
          state_d = last_data ? STOP : DATA;
        end
        STOP: if (mid_tick) begin
          err_d = err_q | ~smp;
          bit_d = bit_q + 4'd1;
          if (last_stop) begin
            state_d     = IDLE;
            data_d      = word_q ? shift_q : {1'b0, shift_q[8:1]};
            frame_err_d = err_q | ~smp;
            valid_d     = 1'b1;
            hold_d      = ~smp;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      div_q       <= MIN_DIV;
      word_q      <= 1'b0;
      stop_q      <= 1'b0;
      shift_q     <= 9'd0;
      bit_q       <= 4'd0;
      err_q       <= 1'b0;
      hold_q      <= 1'b0;
      data_q      <= 9'd0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      div_q       <= div_d;
      word_q      <= word_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
    end
  end
  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a timing/data model of the receiver.
module tb_uart_rx;
  localparam int S = 2;
  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       err;
    logic       busy;
  } ev_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_in = 1'b1;
  logic [11:0] control = 12'd0;
  logic [8:0]  data;
  logic        valid, busy, frame_err;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  ev_t         evq[$];
  uart_rx #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .control   (control),
    .rx_in     (rx_in),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) evq.push_back('{cyc, data, frame_err, busy});
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  function automatic logic [11:0] mk(input int br, input bit w, input bit st, input bit en);
    return {en, st, w, 9'(br)};
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [8:0] v, input int nb, input int ns, input int dv, input bit stop_ok, output int d);
    d = cyc;
    rx_in = 1'b0;
    tick(dv);
    for (int i = 0; i < nb; i++) begin
      rx_in = v[i];
      tick(dv);
    end
    for (int i = 0; i < ns; i++) begin
      rx_in = stop_ok;
      tick(dv);
    end
    rx_in = 1'b1;
  endtask
  // valid appears SYNC latency + half bit + (data+stop bits) periods + 1 after the start edge
  task automatic expect_frame(input string tag, input int d, input logic [8:0] v, input int nb, input int ns,
                              input int dv, input bit err, output int lat);
    ev_t e;
    logic [8:0] m;
    m = (nb == 8) ? {1'b0, v[7:0]} : v;
    lat = -1;
    tests++;
    assert (evq.size() > 0) else begin
      fails++;
      $error("FAIL %s_valid: got 0 pulses expected 1", tag);
    end
    if (evq.size() > 0) begin
      e = evq.pop_front();
      lat = e.cyc - d;
      chk({tag, "_lat"}, lat, S + dv / 2 + (nb + ns) * dv + 1);
      chk({tag, "_data"}, e.data, m);
      chk({tag, "_err"}, e.err, err);
      chk({tag, "_busy"}, e.busy, 0);
    end
  endtask
  initial begin
    int d, d2, l1, l2, br, dv, nb, ns;
    logic [8:0] v;
    bit ok, w, st;
    control = mk(8, 0, 0, 1);
    tick(3);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b1;
    tick(3);
    send(9'h08E, 8, 1, 8, 1, d);
    tick(S + 12);
    expect_frame("basic", d, 9'h08E, 8, 1, 8, 0, l1);
    chk("basic_busy_after", busy, 0);
    chk("basic_single", evq.size(), 0);
    control = mk(8, 1, 0, 1);
    tick(2);
    send(9'h1FE, 9, 1, 8, 1, d);
    tick(S + 12);
    expect_frame("word9", d, 9'h1FE, 9, 1, 8, 0, l2);
    control = mk(8, 0, 1, 1);
    tick(2);
    send(9'h081, 8, 2, 8, 1, d);
    tick(S + 12);
    expect_frame("stop2", d, 9'h081, 8, 2, 8, 0, l2);
    chk("stop2_delta", l2 - l1, 8);
    control = mk(8, 0, 0, 1);
    tick(2);
    send(9'h055, 8, 1, 8, 0, d);
    tick(S + 12);
    expect_frame("ferr", d, 9'h055, 8, 1, 8, 1, l2);
    chk("ferr_held", frame_err, 1);
    send(9'h03C, 8, 1, 8, 1, d);
    tick(S + 12);
    expect_frame("ferr_clear", d, 9'h03C, 8, 1, 8, 0, l2);
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    tick(1);
    chk("false_busy_hi", busy, 1);
    tick(8);
    chk("false_busy_lo", busy, 0);
    chk("false_novalid", evq.size(), 0);
    send(9'h0A5, 8, 1, 8, 1, d);
    tick(S + 12);
    expect_frame("after_false", d, 9'h0A5, 8, 1, 8, 0, l2);
    v = 9'h05A;
    rx_in = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      rx_in = v[i];
      tick(8);
    end
    rx_in = v[3];
    tick(4);
    chk("abort_busy_hi", busy, 1);
    control = mk(8, 0, 0, 0);
    rx_in = 1'b1;
    tick(1);
    chk("abort_busy_lo", busy, 0);
    tick(100);
    chk("abort_novalid", evq.size(), 0);
    chk("abort_data_kept", data, 9'h0A5);
    control = mk(8, 0, 0, 1);
    tick(3);
    v = 9'h0F3;
    rx_in = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++) begin
      rx_in = v[i];
      tick(8);
    end
    tick(3);
    chk("rst_mid_busy_hi", busy, 1);
    rst = 1'b0;
    rx_in = 1'b1;
    tick(1);
    chk("rst_mid_data", data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", valid, 0);
    chk("rst_mid_ferr", frame_err, 0);
    rst = 1'b1;
    tick(100);
    chk("rst_mid_novalid", evq.size(), 0);
    send(9'h012, 8, 1, 8, 1, d);
    tick(S + 12);
    expect_frame("after_rst", d, 9'h012, 8, 1, 8, 0, l2);
    d = cyc;
    rx_in = 1'b0;
    tick(120);
    expect_frame("break", d, 9'h000, 8, 1, 8, 1, l2);
    tick(60);
    chk("break_hold", evq.size(), 0);
    chk("break_idle", busy, 0);
    rx_in = 1'b1;
    tick(4);
    send(9'h0C7, 8, 1, 8, 1, d);
    tick(S + 12);
    expect_frame("after_break", d, 9'h0C7, 8, 1, 8, 0, l2);
    fork
      send(9'h001, 8, 1, 8, 1, d);
      begin
        tick(12);
        control = mk(16, 0, 0, 1);
      end
    join
    send(9'h0FF, 8, 1, 16, 1, d2);
    tick(S + 20);
    expect_frame("b2b_first", d, 9'h001, 8, 1, 8, 0, l2);
    expect_frame("b2b_second", d2, 9'h0FF, 8, 1, 16, 0, l2);
    chk("b2b_count", evq.size(), 0);
    for (int k = 0; k < 10; k++) begin
      br = $urandom_range(0, 20);
      dv = (br < 2) ? 2 : br;
      w  = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      ok = ($urandom_range(0, 3) != 0);
      v  = 9'($urandom_range(0, 511));
      nb = w ? 9 : 8;
      ns = st ? 2 : 1;
      control = mk(br, w, st, 1);
      tick(3);
      send(v, nb, ns, dv, ok, d);
      tick(S + dv + 6);
      expect_frame("rand", d, v, nb, ns, dv, !ok, l2);
      chk("rand_count", evq.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the companion of uart_tx, using the same ctrl_reg_t control word. It samples the serial line, detects the start bit, shifts in 8 or 9 data bits LSB-first and checks 1 or 2 stop bits. It presents the word on a parallel output with a one-cycle valid strobe. It sits between the board RX pin and the peripheral register/FIFO logic.

Parameters:
SYNC_STAGES, 2, number of flops in the rx_in synchronizer (allowed values 2 or 3)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low (rst=0 resets on the next clk rising edge)
control  input  12  ctrl_reg_t: br_div[8:0] (clocks per bit), word (0 = 8 data bits, 1 = 9 data bits), stop (0 = 1 stop bit, 1 = 2 stop bits), en
rx_in  input  1  serial line; idles high
data  output  9  received word, right-aligned; bit 8 is 0 in 8-bit mode
valid  output  1  one-cycle pulse when data/frame_err update
busy  output  1  high from start-bit detect until the frame ends or aborts
frame_err  output  1  a stop bit sampled low in the last frame; held until the next valid

Behaviour:
- Reset (rst=0 at a clk edge):
  - data=0, valid=0, busy=0, frame_err=0.
  - State goes to IDLE and the bit counter clears.
  - Synchronizer flops are set to 1.
  - A reset mid-frame discards the frame; no valid is produced.
- Synchronizer: rx_in passes through SYNC_STAGES flops; all logic uses the synchronized value rx_s. Input-to-detect latency is SYNC_STAGES clocks.
- Effective divisor: div = max(br_div, 2). Half-bit point: half = div>>1.
- States (rx_state_t): IDLE, START, DATA, STOP.
- IDLE:
  - Requires en=1.
  - On rx_s==0, enter START: latch div, word and stop; clear the tick counter; busy=1.
- START:
  - After half clocks, sample rx_s.
  - rx_s=1 is a false start: go to IDLE, busy=0, no valid.
  - rx_s=0: go to DATA and reload the counter.
- DATA:
  - Sample every div clocks at mid-bit; shift LSB-first.
  - 8 bits are taken when word=0, 9 when word=1. Then go to STOP.
- STOP:
  - Sample 1 or 2 stop bits, each div clocks apart.
  - Any stop sample = 0 sets the error for this frame.
  - After the final stop sample, in the next clock: data<=shifted word, frame_err<=error, valid=1 for exactly one clock, busy=0, state to IDLE.
  - The receiver re-arms immediately: a falling edge in the very next clock is detected.
- Latched control: changes to br_div, word or stop mid-frame take effect on the next frame only.
- en=0: in IDLE it blocks detection. Mid-frame it aborts to IDLE at the next clock with busy=0 and no valid; data and frame_err keep their previous values.
- No backpressure: the consumer must capture data on valid. A new frame overwrites data.
- Line held low (break): produces a frame with data=0 and frame_err=1, then waits in IDLE until rx_s returns to 1 before re-arming.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined:
  - Each bit value is the 2-of-3 majority of rx_s sampled at half-1, half and half+1 (relative to the bit start).
  - The start-bit check uses the same vote.
  - div is clamped to a minimum of 4.
- Undefined: a single sample at half, and div is clamped to a minimum of 2.

Decomposition:
- data_types_pkg: reuse ctrl_reg_t; add the rx_state_t enum (IDLE, START, DATA, STOP) and the constant MIN_DIV.
- One sub-module, uart_baud_counter:
  - Loadable down-counter, 9 bits wide.
  - Produces a mid-bit tick and a bit-end tick.
  - Reusable by uart_tx later.

Test Plan:
- Basic 8-bit frame: br_div=8, word=0, stop=0, en=1; drive frame 0x8E at 8 clocks/bit -> one valid pulse, data=0x08E, frame_err=0, busy low after the pulse.
- 9-bit frame: word=1, send 0x1FE -> data=0x1FE. Then 2 stop bits (stop=1), send 0x81 -> data=0x081, valid only after the second stop sample (8 clocks later than with 1 stop bit).
- Framing error: send 0x55 with the stop bit driven low -> valid pulse with data=0x055, frame_err=1. The next good frame 0x3C clears frame_err to 0.
- False start: rx_in low for 2 clocks then high, br_div=8 -> no valid, busy returns to 0 at half-bit. A following 0xA5 frame is received correctly.
- Abort and reset mid-frame:
  - en dropped during bit 3 -> busy=0, no valid, data unchanged.
  - rst=0 during bit 5 -> all outputs 0 next clock.
  - A subsequent 0x12 frame is received correctly.
- Back-to-back frames: 0x01 then 0xFF with zero idle gap and a br_div=16 change mid-frame -> two valid pulses, the second frame using div 16.
